// File: rtl/mc_mem_unit.sv
// mc_mem_unit: memory-access stage behind the multicycle RV64 controller.
// Takes the controller's MemRead / MemWrite / IorD / IRWrite strobes and
// drives a variable-latency req/ack memory port. It holds the instruction
// register (IR) and the memory data register (MDR). It returns a stall that
// freezes the controller state register while an access is in flight.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   ctl_mem_read/write    controller access strobes (both set -> write + err)
//   ctl_iord              address select: 0 = pc, 1 = alu_out
//   ctl_ir_write          fetch: load the addressed 32-bit half into IR
//   pc, alu_out           candidate byte addresses
//   store_data            write data for sd
//   ir_out, mdr_out       IR / MDR contents
//   stall                 combinational controller hold
//   mem_req/we/addr/wdata registered memory request, held until ack
//   mem_ack, mem_rdata    one-cycle completion with read data
//   err                   sticky: misaligned access, read+write, or timeout
//   stall_cycles          (STALL_COUNTER_EN only) saturating stall count
//
// Optional feature macro: STALL_COUNTER_EN
module mc_mem_unit #(
  parameter int XLEN    = 64,
  parameter int ILEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ctl_mem_read,
  input  logic              ctl_mem_write,
  input  logic              ctl_iord,
  input  logic              ctl_ir_write,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [XLEN-1:0]   store_data,
  output logic [ILEN-1:0]   ir_out,
  output logic [XLEN-1:0]   mdr_out,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata,
`ifdef STALL_COUNTER_EN
  output logic [31:0]       stall_cycles,
`endif
  output logic              err
);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  // The counter holds (REQ cycles so far - 1); the TIMEOUT-th REQ cycle
  // without ack is the abort cycle.
  localparam logic [7:0]      CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [ILEN-1:0] IR_NOP   = ILEN'(32'h0000_0013);

  state_t            r_state;
  logic              r_mem_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic              r_half;
  logic [ILEN-1:0]   r_ir;
  logic [XLEN-1:0]   r_mdr;
  logic              r_err;
  logic [7:0]        r_cnt;

  logic              w_req;
  logic [ADDR_W-1:0] w_addr;
  logic              w_aligned;
  logic              w_timeout;
  logic              w_idle;
  logic              w_busy;

  assign w_req     = ctl_mem_read | ctl_mem_write;
  assign w_addr    = ctl_iord ? alu_out : pc;
  // Fetches only need word alignment (either half of the doubleword);
  // data accesses are full doublewords.
  assign w_aligned = ctl_ir_write ? (w_addr[1:0] == 2'b00)
                                  : (w_addr[2:0] == 3'b000);
  assign w_idle    = (r_state == S_IDLE);
  assign w_busy    = (r_state == S_REQ);
  assign w_timeout = w_busy & ~mem_ack & (r_cnt == CNT_LAST);

  // Ack releases stall in the same cycle, so the controller advances on the
  // ack edge and the next access is seen in IDLE right after.
  assign stall = (w_idle & w_req & w_aligned) | (w_busy & ~mem_ack & ~w_timeout);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_mem_req <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_half    <= 1'b0;
      r_ir      <= IR_NOP;
      r_mdr     <= '0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (w_aligned) begin
              r_addr    <= {w_addr[ADDR_W-1:3], 3'b000};
              r_we      <= ctl_mem_write;
              r_wdata   <= store_data;
              r_half    <= w_addr[2];
              r_mem_req <= 1'b1;
              r_cnt     <= '0;
              r_state   <= S_REQ;
              if (ctl_mem_read & ctl_mem_write) r_err <= 1'b1;
            end else begin
              // Dropped access: no request, controller is not held.
              r_err <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            if (!r_we) begin
              r_mdr <= mem_rdata;
              if (ctl_ir_write)
                r_ir <= r_half ? mem_rdata[2*ILEN-1:ILEN] : mem_rdata[ILEN-1:0];
            end
            r_mem_req <= 1'b0;
            r_cnt     <= '0;
            r_state   <= S_IDLE;
          end else if (w_timeout) begin
            r_mem_req <= 1'b0;
            r_cnt     <= '0;
            r_err     <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef STALL_COUNTER_EN
  logic [31:0] r_stall_cycles;
  always_ff @(posedge clk) begin
    if (reset)
      r_stall_cycles <= '0;
    else if (stall && (r_stall_cycles != 32'hFFFF_FFFF))
      r_stall_cycles <= r_stall_cycles + 32'd1;
  end
  assign stall_cycles = r_stall_cycles;
`endif

  assign mem_req   = r_mem_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign ir_out    = r_ir;
  assign mdr_out   = r_mdr;
  assign err       = r_err;

endmodule
